// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch resolution controller.
// Takes one branch at a time and stalls the front end until its operands have
// been forwarded. It then feeds the latched operands to the external CMP
// comparator and turns the comparator flags into a registered redirect.
module branch_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_op,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_imm,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        rs_ready,
  input  logic        rt_ready,
  input  logic        flush,
  output logic [31:0] cmp_rs,
  output logic [31:0] cmp_rt,
  input  logic        cmp_zero,
  input  logic        cmp_gzero,
  input  logic        cmp_lzero,
  output logic        stall,
  output logic        res_valid,
  output logic        res_taken,
  output logic [31:0] res_target,
  output logic        hazard_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EVAL = 2'd2
  } state_t;

  localparam logic [2:0] OP_BEQ  = 3'd0;
  localparam logic [2:0] OP_BNE  = 3'd1;
  localparam logic [2:0] OP_BGTZ = 3'd2;
  localparam logic [2:0] OP_BLEZ = 3'd3;
  localparam logic [2:0] OP_BLTZ = 3'd4;
  localparam logic [2:0] OP_BGEZ = 3'd5;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  // Turns the comparator flags into a taken decision; reserved ops never branch.
  function automatic logic branch_taken(input logic [2:0] op, input logic zero,
                                        input logic gzero, input logic lzero);
    case (op)
      OP_BEQ:  return zero;
      OP_BNE:  return ~zero;
      OP_BGTZ: return gzero;
      OP_BLEZ: return ~gzero;
      OP_BLTZ: return lzero;
      OP_BGEZ: return ~lzero;
      default: return 1'b0;
    endcase
  endfunction

  // Next fetch PC. The word offset is relative to the delay slot; a not-taken
  // branch skips the delay slot. Arithmetic wraps modulo 2^32.
  function automatic logic [31:0] branch_target(input logic taken, input logic [31:0] pc,
                                                input logic signed [15:0] imm);
    logic signed [31:0] ofs;
    ofs = {{14{imm[15]}}, imm, 2'b00};
    if (taken) return pc + 32'd4 + ofs;
    return pc + 32'd8;
  endfunction

  state_t              state;
  logic [2:0]          op_p0;
  logic [31:0]         pc_p0;
  logic signed [15:0]  imm_p0;
  logic [WAIT_W-1:0]   wait_cnt;

  logic [2:0]          op_sel;
  logic                ops_ok;
  logic                taken;
  logic [31:0]         target;

  // Operand readiness uses the incoming op while idle, the latched op afterwards;
  // single-operand branches do not wait for RT.
  always_comb begin
    op_sel   = (state == S_IDLE) ? br_op : op_p0;
    ops_ok   = rs_ready & (rt_ready | (op_sel >= OP_BGTZ));
    br_ready = (state == S_IDLE) & ~flush;
    stall    = (state != S_IDLE);
    taken    = branch_taken(op_p0, cmp_zero, cmp_gzero, cmp_lzero);
    target   = branch_target(taken, pc_p0, imm_p0);
  end

  // Control FSM with registered operand latches and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      op_p0      <= '0;
      pc_p0      <= '0;
      imm_p0     <= '0;
      wait_cnt   <= '0;
      cmp_rs     <= '0;
      cmp_rt     <= '0;
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      res_target <= '0;
      hazard_err <= 1'b0;
    end else begin
      res_valid  <= 1'b0;
      hazard_err <= 1'b0;
      if (flush) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (br_valid) begin
              op_p0    <= br_op;
              pc_p0    <= br_pc;
              imm_p0   <= br_imm;
              wait_cnt <= '0;
              if (ops_ok) begin
                cmp_rs <= rs_data;
                if (rt_ready) cmp_rt <= rt_data;
                state <= S_EVAL;
              end else begin
                state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (ops_ok) begin
              cmp_rs <= rs_data;
              if (rt_ready) cmp_rt <= rt_data;
              state <= S_EVAL;
            end else if (wait_cnt == WAIT_LAST) begin
              hazard_err <= 1'b1;
              state      <= S_IDLE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_EVAL: begin
            res_valid  <= 1'b1;
            res_taken  <= taken;
            res_target <= target;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: self-checking bench for branch_ctrl with a behavioural CMP
// unit, a table of directed branches, multi-cycle corner sequences and
// randomized transactions checked against a transaction-level model.
module tb_branch_ctrl;

  localparam int WAIT_MAX = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_op;
  logic [31:0] br_pc;
  logic [15:0] br_imm;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        rs_ready;
  logic        rt_ready;
  logic        flush;
  logic [31:0] cmp_rs;
  logic [31:0] cmp_rt;
  logic        cmp_zero;
  logic        cmp_gzero;
  logic        cmp_lzero;
  logic        stall;
  logic        res_valid;
  logic        res_taken;
  logic [31:0] res_target;
  logic        hazard_err;

  int          checks   = 0;
  int          failures = 0;
  int          txn_id   = 0;
  logic        m_taken  = 1'b0;
  logic [31:0] m_target = 32'd0;

  always #5 clk = ~clk;

  // Behavioural CMP comparator
  assign cmp_zero  = (cmp_rs == cmp_rt);
  assign cmp_gzero = ($signed(cmp_rs) > 0);
  assign cmp_lzero = ($signed(cmp_rs) < 0);

  branch_ctrl #(.WAIT_MAX(WAIT_MAX), .WAIT_W(4)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_ready(br_ready),
    .br_op(br_op), .br_pc(br_pc), .br_imm(br_imm),
    .rs_data(rs_data), .rt_data(rt_data), .rs_ready(rs_ready), .rt_ready(rt_ready),
    .flush(flush), .cmp_rs(cmp_rs), .cmp_rt(cmp_rt),
    .cmp_zero(cmp_zero), .cmp_gzero(cmp_gzero), .cmp_lzero(cmp_lzero),
    .stall(stall), .res_valid(res_valid), .res_taken(res_taken),
    .res_target(res_target), .hazard_err(hazard_err)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        rt_rdy;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[15];

  task automatic chk1(input string what, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL txn %0d %s: actual=%b required=%b", txn_id, what, act, exp);
    end
  endtask

  task automatic chk32(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL txn %0d %s: actual=%08h required=%08h", txn_id, what, act, exp);
    end
  endtask

  function automatic logic model_taken(input logic [2:0] op, input logic [31:0] rs,
                                       input logic [31:0] rt);
    case (op)
      3'd0:    return rs == rt;
      3'd1:    return rs != rt;
      3'd2:    return $signed(rs) > 0;
      3'd3:    return $signed(rs) <= 0;
      3'd4:    return $signed(rs) < 0;
      3'd5:    return $signed(rs) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target(input logic tk, input logic [31:0] pc,
                                               input logic [15:0] imm);
    int off;
    off = int'($signed(imm)) * 4;
    return tk ? (pc + 32'd4 + 32'(off)) : (pc + 32'd8);
  endfunction

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // One branch: operands become ready d_rs/d_rt cycles after the accept cycle,
  // optional flush at cycle flush_at (accept cycle = 0). Expected behaviour is
  // derived from when both needed operands are first available.
  task automatic run_txn(input logic [2:0] op, input logic [31:0] pc, input logic [15:0] imm,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input int d_rs, input int d_rt, input int flush_at,
                         input logic exp_taken, input logic [31:0] exp_target);
    int jstar;
    int last_busy;
    int end_cyc;
    bit hazard;
    bit flushed;
    jstar     = (op < 3'd2 && d_rt > d_rs) ? d_rt : d_rs;
    hazard    = (jstar > WAIT_MAX);
    last_busy = hazard ? WAIT_MAX : jstar + 1;
    flushed   = (flush_at >= 1 && flush_at <= last_busy);
    if (flushed) last_busy = flush_at;
    end_cyc = last_busy + 1;
    txn_id++;
    for (int j = 0; j <= end_cyc; j++) begin
      @(posedge clk);
      #1;
      br_valid = (j == 0) ? 1'b1 : ((j <= last_busy) ? 1'($urandom_range(0, 1)) : 1'b0);
      br_op    = (j == 0) ? op : 3'($urandom_range(0, 7));
      br_pc    = (j == 0) ? pc : $urandom;
      br_imm   = (j == 0) ? imm : 16'($urandom);
      rs_ready = (j >= d_rs);
      rs_data  = rs_ready ? rs : $urandom;
      rt_ready = (j >= d_rt);
      rt_data  = rt_ready ? rt : $urandom;
      flush    = flushed && (j == flush_at);
      #1;
      if (!flushed && !hazard && j == jstar + 2) begin
        m_taken  = exp_taken;
        m_target = exp_target;
      end
      chk1("stall", stall, (j >= 1 && j <= last_busy));
      chk1("br_ready", br_ready, !(j >= 1 && j <= last_busy) && !flush);
      chk1("res_valid", res_valid, !flushed && !hazard && j == jstar + 2);
      chk1("hazard_err", hazard_err, !flushed && hazard && j == WAIT_MAX + 1);
      chk1("res_taken", res_taken, m_taken);
      chk32("res_target", res_target, m_target);
      if (!hazard && j == jstar + 1 && j <= last_busy) begin
        chk32("cmp_rs", cmp_rs, rs);
        if (d_rt <= jstar) chk32("cmp_rt", cmp_rt, rt);
      end
    end
    br_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_pc, r_rs, r_rt;
    logic [15:0] r_imm;
    int          r_drs, r_drt, r_fl;
    logic        r_tk;

    vecs[0]  = '{3'd0, 32'h0000_0100, 16'h0004, 32'd5,         32'd5, 1'b1, 1'b1, 32'h0000_0114};
    vecs[1]  = '{3'd1, 32'h0000_0200, 16'h0008, 32'd1,         32'd1, 1'b1, 1'b0, 32'h0000_0208};
    vecs[2]  = '{3'd1, 32'h0000_0200, 16'h0008, 32'd1,         32'd2, 1'b1, 1'b1, 32'h0000_0224};
    vecs[3]  = '{3'd2, 32'h0000_1000, 16'hFFFE, 32'd1,         32'd0, 1'b0, 1'b1, 32'h0000_0FFC};
    vecs[4]  = '{3'd2, 32'h0000_0040, 16'h0005, 32'd0,         32'd0, 1'b0, 1'b0, 32'h0000_0048};
    vecs[5]  = '{3'd3, 32'h0000_0040, 16'h0001, 32'd0,         32'd0, 1'b0, 1'b1, 32'h0000_0048};
    vecs[6]  = '{3'd3, 32'h0000_0000, 16'h0002, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 32'h0000_000C};
    vecs[7]  = '{3'd4, 32'h0000_0000, 16'hFFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[8]  = '{3'd5, 32'h0000_0010, 16'h0003, 32'd0,         32'd0, 1'b1, 1'b1, 32'h0000_0020};
    vecs[9]  = '{3'd5, 32'h0000_0010, 16'h0003, 32'h8000_0000, 32'd0, 1'b1, 1'b0, 32'h0000_0018};
    vecs[10] = '{3'd7, 32'h0000_0300, 16'h0001, 32'd0,         32'd0, 1'b1, 1'b0, 32'h0000_0308};
    vecs[11] = '{3'd6, 32'h0000_0300, 16'h0001, 32'd3,         32'd3, 1'b1, 1'b0, 32'h0000_0308};
    vecs[12] = '{3'd0, 32'hFFFF_FFFC, 16'h0001, 32'd9,         32'd9, 1'b1, 1'b1, 32'h0000_0004};
    vecs[13] = '{3'd1, 32'h7FFF_FFFC, 16'h7FFF, 32'd1,         32'd2, 1'b1, 1'b1, 32'h8001_FFFC};
    vecs[14] = '{3'd2, 32'h0000_0000, 16'h8000, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 32'hFFFE_0004};

    reset = 1'b1; br_valid = 1'b0; br_op = '0; br_pc = '0; br_imm = '0;
    rs_data = '0; rt_data = '0; rs_ready = 1'b0; rt_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk1("reset stall", stall, 1'b0);
    chk1("reset br_ready", br_ready, 1'b1);
    chk1("reset res_valid", res_valid, 1'b0);
    chk1("reset res_taken", res_taken, 1'b0);
    chk32("reset res_target", res_target, 32'd0);
    chk1("reset hazard_err", hazard_err, 1'b0);
    chk32("reset cmp_rs", cmp_rs, 32'd0);
    chk32("reset cmp_rt", cmp_rt, 32'd0);

    // Directed table: operands ready at accept
    for (int i = 0; i < 15; i++)
      run_txn(vecs[i].op, vecs[i].pc, vecs[i].imm, vecs[i].rs, vecs[i].rt,
              0, vecs[i].rt_rdy ? 0 : 99, -1, vecs[i].exp_taken, vecs[i].exp_target);

    // BNE with RT late by three cycles
    run_txn(3'd1, 32'h0000_0400, 16'h0010, 32'd1, 32'd1, 0, 3, -1, 1'b0, 32'h0000_0408);
    // BGEZ whose RS never arrives: timeout abort
    run_txn(3'd5, 32'h0000_0800, 16'h0001, 32'd0, 32'd0, 99, 99, -1, 1'b0, 32'd0);
    // BGEZ whose RS arrives on the last permitted WAIT cycle
    run_txn(3'd5, 32'h0000_0900, 16'h0002, 32'd5, 32'd0, 15, 99, -1, 1'b1, 32'h0000_090C);
    // Flush during WAIT and during EVAL
    run_txn(3'd0, 32'h0000_0A00, 16'h0001, 32'd3, 32'd3, 99, 0, 5, 1'b1, 32'h0000_0A08);
    run_txn(3'd0, 32'h0000_0B00, 16'h0001, 32'd3, 32'd3, 0, 0, 1, 1'b1, 32'h0000_0B08);

    // Randomized transactions against the model
    for (int n = 0; n < 80; n++) begin
      r_op  = 3'($urandom_range(0, 7));
      r_rs  = pick_val();
      r_rt  = ($urandom_range(0, 1) == 0) ? r_rs : pick_val();
      r_pc  = $urandom;
      r_imm = 16'($urandom);
      r_drs = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : int'($urandom_range(0, 2));
      r_drt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : int'($urandom_range(0, 2));
      r_fl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 17)) : -1;
      r_tk  = model_taken(r_op, r_rs, r_rt);
      run_txn(r_op, r_pc, r_imm, r_rs, r_rt, r_drs, r_drt, r_fl, r_tk,
              model_target(r_tk, r_pc, r_imm));
    end

    // Flush together with a request in IDLE: not accepted
    txn_id++;
    @(posedge clk); #1;
    br_valid = 1'b1; flush = 1'b1; br_op = 3'd0; rs_ready = 1'b1; rt_ready = 1'b1;
    #1 chk1("flush idle br_ready", br_ready, 1'b0);
    @(posedge clk); #1;
    br_valid = 1'b0; flush = 1'b0;
    #1 chk1("flush idle stall", stall, 1'b0);
    chk1("flush idle res_valid", res_valid, 1'b0);
    @(posedge clk); #1; #1;
    chk1("flush idle stall2", stall, 1'b0);
    chk1("flush idle res_valid2", res_valid, 1'b0);

    // Back-to-back: second branch accepted on the first result's pulse cycle
    txn_id++;
    @(posedge clk); #1;
    br_valid = 1'b1; br_op = 3'd0; br_pc = 32'h100; br_imm = 16'd4;
    rs_data = 32'd5; rt_data = 32'd5; rs_ready = 1'b1; rt_ready = 1'b1;
    #1 chk1("b2b accept1", br_ready, 1'b1);
    @(posedge clk); #1;
    br_valid = 1'b0;
    #1 chk1("b2b eval stall", stall, 1'b1);
    chk1("b2b eval res_valid", res_valid, 1'b0);
    @(posedge clk); #1;
    br_valid = 1'b1; br_op = 3'd1; br_pc = 32'h500; br_imm = 16'hFFFF;
    rs_data = 32'd7; rt_data = 32'd7;
    #1 chk1("b2b pulse1", res_valid, 1'b1);
    chk1("b2b taken1", res_taken, 1'b1);
    chk32("b2b target1", res_target, 32'h114);
    chk1("b2b accept2", br_ready, 1'b1);
    @(posedge clk); #1;
    br_valid = 1'b0;
    #1 chk1("b2b eval2 stall", stall, 1'b1);
    chk1("b2b eval2 res_valid", res_valid, 1'b0);
    @(posedge clk); #1; #1;
    chk1("b2b pulse2", res_valid, 1'b1);
    chk1("b2b taken2", res_taken, 1'b0);
    chk32("b2b target2", res_target, 32'h508);
    chk1("b2b idle stall", stall, 1'b0);
    m_taken = 1'b0; m_target = 32'h508;

    // Reset in the middle of a WAIT
    txn_id++;
    @(posedge clk); #1;
    br_valid = 1'b1; br_op = 3'd5; rs_ready = 1'b0; rt_ready = 1'b0;
    #1 chk1("rst-mid accept", br_ready, 1'b1);
    @(posedge clk); #1;
    br_valid = 1'b0;
    #1 chk1("rst-mid waiting", stall, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1 chk1("rst-mid stall", stall, 1'b0);
    chk1("rst-mid res_valid", res_valid, 1'b0);
    chk1("rst-mid hazard_err", hazard_err, 1'b0);
    chk1("rst-mid res_taken", res_taken, 1'b0);
    chk32("rst-mid res_target", res_target, 32'd0);
    chk32("rst-mid cmp_rs", cmp_rs, 32'd0);
    chk32("rst-mid cmp_rt", cmp_rt, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_taken = 1'b0; m_target = 32'd0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1; #1;
      chk1("post-rst stall", stall, 1'b0);
      chk1("post-rst hazard_err", hazard_err, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
